seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshakes on operand and result sides.
//  Successor to the board's 4-bit combinational ALU: width is generic, the op is latched with its operands, and SLT is sign-correct.
//  Adds an optional multi-cycle shift-add multiplier.
//  Sits between the switch/button input logic in top and the seg display, or any future datapath master.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2); operands are two's complement
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  resetn     in   1      asynchronous, active-low reset
//  in_valid   in   1      operands+op presented
//  in_ready   out  1      block can accept a request this cycle
//  op         in   4      operation code (see BEHAVIOUR)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result registers hold a valid result
//  out_ready  in   1      consumer accepts the result
//  res        out  WIDTH  result (MUL: low half)
//  res_hi     out  WIDTH  MUL high half; 0 for all other ops
//  zero       out  1      res == 0
//  overflow   out  1      signed overflow (ADD/SUB/SLT only)
//  carry      out  1      carry-out (ADD), no-borrow (SUB), |res_hi (MUL), else 0
//  err        out  1      illegal op code
// BEHAVIOUR
//  - Reset value: all outputs 0 except in_ready=1; FSM=IDLE; counter=0.
//  - Reset mid-operation: asynchronous abort, no result is produced, block returns to IDLE.
//  - Accept: a request is taken on a clk edge where in_valid && in_ready.
//    a, b and op are captured in that cycle; later input changes are ignored.
//  - Op codes:
//      0 ADD    a+b
//      1 SUB    a+~b+1
//      2 NOT    ~a
//      3 AND
//      4 OR
//      5 XOR
//      6 SLT    res=1 when signed a<b, i.e. diff[MSB]^ovf
//      7 EQ     res=1 when a==b
//      8 MUL    unsigned a*b, 2*WIDTH-bit product
//    Codes 9-15, and code 8 when MUL is compiled out: illegal.
//    Illegal op: res=0, res_hi=0, err=1, zero=1, other flags 0.
//  - Arithmetic is done at WIDTH+1 bits; carry is bit WIDTH of that sum.
//    overflow = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' = b for ADD and ~b for SUB/SLT.
//  - FSM IDLE -> DONE: single-cycle op; out_valid rises 1 cycle after accept.
//  - FSM IDLE -> BUSY: MUL; runs WIDTH iterations, then BUSY -> DONE; out_valid rises WIDTH+1 cycles after accept.
//  - FSM DONE -> IDLE: on out_ready.
//    If in_valid is also high in that cycle, the new request is accepted in the same cycle (back-to-back, zero bubble).
//  - in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is 0 throughout BUSY.
//  - While out_valid && !out_ready, res/res_hi/flags/err are held stable.
//  - zero is always derived from the registered res (MUL: low half only).
// CONFIGURATION
//  SEQ_ALU_MUL_EN defined:
//    - op 8 is MUL, using the seq_alu_mul instance and the BUSY state.
//  SEQ_ALU_MUL_EN undefined:
//    - no multiplier logic and no BUSY state; op 8 is illegal.
//    - res_hi is tied to 0; every op has latency 1.
// STRUCTURE
//  - Package seq_alu_pkg:
//    - op code localparams OP_ADD..OP_MUL
//    - FSM state encoding S_IDLE/S_BUSY/S_DONE
//    - function is_legal_op()
//  - Sub-module seq_alu_mul (only under SEQ_ALU_MUL_EN):
//    - shift-add engine, WIDTH cycles
//    - ports: start, a, b -> done, prod[2*WIDTH-1:0]
//    - holds a $clog2(WIDTH+1)-bit iteration counter
//  - The top-level file holds the FSM, the handshake logic, the combinational single-cycle datapath and the result registers.
// TESTING (WIDTH=4)
//  1. ADD a=7, b=1: res=8, ovf=1, carry=0, zero=0; out_valid exactly 1 cycle after accept.
//  2. SUB a=3, b=5: res=0xE, carry=0, ovf=0. SUB a=5, b=5: res=0, zero=1, carry=1.
//  3. SLT a=0x8 (-8), b=7: res=1, ovf=1.
//     SLT a=7, b=0x8: res=0.
//     EQ a=9, b=9: res=1.
//  4. MUL (macro on) a=15, b=15: res=0x1, res_hi=0xE, carry=1.
//     out_valid exactly 5 cycles after accept; in_ready=0 while BUSY.
//  5. Backpressure: hold out_ready=0 for 3 cycles after a result.
//     Result and flags stay stable and in_ready=0.
//     Then assert out_ready together with in_valid (XOR a=0xA, b=0x5): the new request is accepted in that same cycle; next result is 0xF.
//  6. Drop resetn mid-MUL (cycle 2):
//     outputs go to reset values immediately and in_ready=1.
//     After release, op=0xF gives err=1, res=0, zero=1.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state encoding and op legality for seq_alu.
// Legality of OP_MUL follows the SEQ_ALU_MUL_EN build macro.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLT = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
`ifdef SEQ_ALU_MUL_EN
        return op <= OP_MUL;
`else
        return op <= OP_EQ;
`endif
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Shift-add unsigned multiplier: loads on start, then one partial product per
// cycle for WIDTH cycles; done stays high for the cycle after the last step.
module seq_alu_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            prod   <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            if (cnt != '0) begin
                if (mplier[0])
                    prod <= prod + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (cnt == '0);

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both sides.
// Define SEQ_ALU_MUL_EN to build in the multi-cycle multiplier (op 8).
//
// state  | meaning
// S_IDLE | waiting for a request
// S_BUSY | multiplier iterating, result not yet available
// S_DONE | result registers valid, waiting for out_ready
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             err
);

    state_t state;
    logic   accept;

    assign in_ready = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign accept   = in_valid && in_ready;

    // One WIDTH+1 adder serves ADD, SUB and SLT; subtraction is a + ~b + 1.
    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf;

    assign sub_mode = (op != OP_ADD);
    assign b_eff    = sub_mode ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    assign ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_carry;

    always_comb begin
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res   = sum[WIDTH-1:0];
                alu_ovf   = ovf;
                alu_carry = sum[WIDTH];
            end
            OP_NOT: alu_res = ~a;
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
                alu_ovf = ovf;
            end
            OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, a == b};
            default: ;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_prod;

    assign mul_start = accept && (op == OP_MUL);

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .resetn (resetn),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .prod   (mul_prod)
    );
`else
    assign res_hi = '0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            res       <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry     <= 1'b0;
            err       <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            res_hi    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                        if (op == OP_MUL) begin
                            state     <= S_BUSY;
                            out_valid <= 1'b0;
                        end else
`endif
                        begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            res       <= alu_res;
                            zero      <= (alu_res == '0);
                            overflow  <= alu_ovf;
                            carry     <= alu_carry;
                            err       <= !is_legal_op(op);
`ifdef SEQ_ALU_MUL_EN
                            res_hi    <= '0;
`endif
                        end
                    end else if (state == S_DONE && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                S_BUSY: begin
                    if (mul_done) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        res       <= mul_prod[WIDTH-1:0];
                        res_hi    <= mul_prod[2*WIDTH-1:WIDTH];
                        zero      <= (mul_prod[WIDTH-1:0] == '0);
                        overflow  <= 1'b0;
                        carry     <= |mul_prod[2*WIDTH-1:WIDTH];
                        err       <= 1'b0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
